eca_engine: RTL and testbench

//   Parametrised elementary cellular automaton engine; generalises the fixed rule-110 core.

---
 rtl/eca_engine.sv | 138 +++++++++++++
 tb/tb_eca_engine.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/eca_engine.sv
// rtl/eca_engine.sv - elementary cellular automaton engine with block-addressed access and a run controller
//
// Ports:
//   clk, reset        clock and synchronous active-high reset
//   cfg_rule_i        Wolfram rule number, captured when a start is accepted
//   cfg_wrap_i        1 = toroidal edges, 0 = constant-pad edges, captured on start
//   cfg_pad_i         edge pad value when not wrapping, captured on start
//   wr_en_i/wr_addr_i/wr_data_i   block write, honoured only in IDLE
//   rd_addr_i/rd_data_o           registered block read, one cycle latency
//   start_i/gen_count_i/stop_i    run control; gen_count_i = 0 free-runs until stop_i
//   busy_o            high in every RUN cycle
//   done_o            one-cycle pulse after a run completes or is stopped
//   stable_o          last generation reproduced the previous state
//   gen_o             generations since reset, wrapping
module eca_engine #(
    parameter int NUM_CELLS = 64,
    parameter int BLOCK_W   = 8,
    parameter int GEN_W     = 16,
    localparam int NUM_BLOCKS = NUM_CELLS / BLOCK_W,
    localparam int ADDR_W     = $clog2(NUM_BLOCKS)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [7:0]         cfg_rule_i,
    input  logic               cfg_wrap_i,
    input  logic               cfg_pad_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [BLOCK_W-1:0] wr_data_i,
    input  logic [ADDR_W-1:0]  rd_addr_i,
    output logic [BLOCK_W-1:0] rd_data_o,
    input  logic               start_i,
    input  logic [GEN_W-1:0]   gen_count_i,
    input  logic               stop_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               stable_o,
    output logic [GEN_W-1:0]   gen_o
);

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    logic [0:0]           state_q;
    logic [NUM_CELLS-1:0] cells_q;
    logic [NUM_CELLS-1:0] cells_d;
    logic [NUM_CELLS-1:0] next_cells;
    logic [NUM_CELLS+1:0] ext;
    logic [7:0]           rule_q;
    logic                 wrap_q;
    logic                 pad_q;
    logic [GEN_W-1:0]     remaining_q;
    logic [BLOCK_W-1:0]   rd_next;

    // ext[0] is the virtual cell[-1], ext[NUM_CELLS+1] the virtual cell[NUM_CELLS],
    // so ext[i +: 3] is exactly {L, C, R} for cell i.
    always_comb begin
        ext = {(wrap_q ? cells_q[0] : pad_q), cells_q, (wrap_q ? cells_q[NUM_CELLS-1] : pad_q)};
        next_cells = '0;
        for (int i = 0; i < NUM_CELLS; i++) begin
            next_cells[i] = rule_q[ext[i +: 3]];
        end
    end

    // Cell update: a write in IDLE or one generation in RUN. Addresses that match
    // no block fall through the loop and leave the cells untouched.
    always_comb begin
        cells_d = cells_q;
        if (state_q == ST_RUN) begin
            cells_d = next_cells;
        end else if (wr_en_i) begin
            for (int b = 0; b < NUM_BLOCKS; b++) begin
                if (wr_addr_i == ADDR_W'(b)) begin
                    cells_d[b*BLOCK_W +: BLOCK_W] = wr_data_i;
                end
            end
        end
    end

    // Read port sees the post-edge cell value, hence it muxes cells_d, not cells_q.
    always_comb begin
        rd_next = '0;
        for (int b = 0; b < NUM_BLOCKS; b++) begin
            if (rd_addr_i == ADDR_W'(b)) begin
                rd_next = cells_d[b*BLOCK_W +: BLOCK_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cells_q     <= NUM_CELLS'(1);
            rule_q      <= 8'd110;
            wrap_q      <= 1'b1;
            pad_q       <= 1'b0;
            remaining_q <= '0;
            rd_data_o   <= '0;
            done_o      <= 1'b0;
            stable_o    <= 1'b0;
            gen_o       <= '0;
        end else begin
            cells_q   <= cells_d;
            rd_data_o <= rd_next;
            done_o    <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (wr_en_i) begin
                        stable_o <= 1'b0;
                    end else if (start_i) begin
                        rule_q      <= cfg_rule_i;
                        wrap_q      <= cfg_wrap_i;
                        pad_q       <= cfg_pad_i;
                        remaining_q <= gen_count_i;
                        state_q     <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    gen_o    <= gen_o + GEN_W'(1);
                    stable_o <= (next_cells == cells_q);
                    // remaining_q == 0 marks a free run; it is never decremented there.
                    if (remaining_q != '0) begin
                        remaining_q <= remaining_q - GEN_W'(1);
                    end
                    if (stop_i || remaining_q == GEN_W'(1)) begin
                        state_q     <= ST_IDLE;
                        remaining_q <= '0;
                        done_o      <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign busy_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_eca_engine.sv
// tb/tb_eca_engine.sv - directed self-checking bench for eca_engine
module tb_eca_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  cfg_rule_i;
    logic        cfg_wrap_i;
    logic        cfg_pad_i;
    logic        wr_en_i;
    logic [2:0]  wr_addr_i;
    logic [7:0]  wr_data_i;
    logic [2:0]  rd_addr_i;
    logic [7:0]  rd_data_o;
    logic        start_i;
    logic [15:0] gen_count_i;
    logic        stop_i;
    logic        busy_o;
    logic        done_o;
    logic        stable_o;
    logic [15:0] gen_o;

    int n_total = 0;
    int n_bad   = 0;

    always #5 clk = ~clk;

    eca_engine dut (
        .clk        (clk),
        .reset      (reset),
        .cfg_rule_i (cfg_rule_i),
        .cfg_wrap_i (cfg_wrap_i),
        .cfg_pad_i  (cfg_pad_i),
        .wr_en_i    (wr_en_i),
        .wr_addr_i  (wr_addr_i),
        .wr_data_i  (wr_data_i),
        .rd_addr_i  (rd_addr_i),
        .rd_data_o  (rd_data_o),
        .start_i    (start_i),
        .gen_count_i(gen_count_i),
        .stop_i     (stop_i),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .stable_o   (stable_o),
        .gen_o      (gen_o)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start_i = 1'b0; stop_i = 1'b0; wr_en_i = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic write_block(input logic [2:0] a, input logic [7:0] d);
        wr_en_i = 1'b1; wr_addr_i = a; wr_data_i = d;
        tick();
        wr_en_i = 1'b0;
    endtask

    task automatic read_all(output logic [63:0] v);
        v = '0;
        for (int b = 0; b < 8; b++) begin
            rd_addr_i = 3'(b);
            tick();
            v[b*8 +: 8] = rd_data_o;
        end
    endtask

    task automatic run(input logic [7:0] rule, input logic w, input logic p,
                       input logic [15:0] cnt, output int busy_cycles, output logic done_seen);
        cfg_rule_i = rule; cfg_wrap_i = w; cfg_pad_i = p; gen_count_i = cnt;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        busy_cycles = 0;
        while (busy_o && busy_cycles < 1000) begin
            busy_cycles++;
            tick();
        end
        done_seen = done_o;
    endtask

    logic [63:0] cells;
    int          bc;
    logic        dn;

    initial begin
        cfg_rule_i = 8'd110; cfg_wrap_i = 1'b1; cfg_pad_i = 1'b0;
        wr_addr_i = '0; wr_data_i = '0; rd_addr_i = '0; gen_count_i = '0;

        // 1: reset state and rule 110 for three generations
        do_reset();
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_stable", stable_o, 0);
        check("rst_gen", gen_o, 0);
        check("rst_rd", rd_data_o, 0);
        read_all(cells);
        check("rst_cells", cells, 64'h1);
        rd_addr_i = 3'd0; cfg_rule_i = 8'd110; cfg_wrap_i = 1'b1; gen_count_i = 16'd3;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        check("t1_busy0", busy_o, 1);
        tick();
        check("t1_g1", rd_data_o, 8'h03);
        check("t1_busy1", busy_o, 1);
        tick();
        check("t1_g2", rd_data_o, 8'h07);
        check("t1_busy2", busy_o, 1);
        tick();
        check("t1_g3", rd_data_o, 8'h0D);
        check("t1_busy3", busy_o, 0);
        check("t1_done", done_o, 1);
        check("t1_gen", gen_o, 3);
        tick();
        check("t1_done_pulse", done_o, 0);
        read_all(cells);
        check("t1_cells", cells, 64'hD);

        // 2: rule 90, wrap vs pad edges
        do_reset();
        run(8'd90, 1'b1, 1'b0, 16'd1, bc, dn);
        check("t2_busy_cnt", bc, 1);
        read_all(cells);
        check("t2_wrap", cells, 64'h8000_0000_0000_0002);
        do_reset();
        run(8'd90, 1'b0, 1'b0, 16'd1, bc, dn);
        read_all(cells);
        check("t2_pad0", cells, 64'h0000_0000_0000_0002);

        // 3: all ones under rule 110 collapses, then stays stable
        do_reset();
        for (int b = 0; b < 8; b++) write_block(3'(b), 8'hFF);
        read_all(cells);
        check("t3_filled", cells, 64'hFFFF_FFFF_FFFF_FFFF);
        run(8'd110, 1'b1, 1'b0, 16'd1, bc, dn);
        check("t3_done1", dn, 1);
        check("t3_stable1", stable_o, 0);
        read_all(cells);
        check("t3_zero1", cells, 64'h0);
        run(8'd110, 1'b1, 1'b0, 16'd1, bc, dn);
        check("t3_stable2", stable_o, 1);
        read_all(cells);
        check("t3_zero2", cells, 64'h0);
        write_block(3'd0, 8'h00);
        check("t3_stable_clr", stable_o, 0);

        // 4: free run stopped after ten busy cycles
        do_reset();
        cfg_rule_i = 8'd110; cfg_wrap_i = 1'b1; gen_count_i = 16'd0;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        for (int i = 0; i < 9; i++) tick();
        check("t4_busy_before_stop", busy_o, 1);
        check("t4_gen9", gen_o, 9);
        stop_i = 1'b1;
        tick();
        stop_i = 1'b0;
        check("t4_gen", gen_o, 10);
        check("t4_done", done_o, 1);
        check("t4_busy", busy_o, 0);

        // 5: writes ignored in RUN, honoured in IDLE; start+write collision
        do_reset();
        cfg_rule_i = 8'd110; cfg_wrap_i = 1'b1; gen_count_i = 16'd4;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        wr_en_i = 1'b1; wr_addr_i = 3'd1; wr_data_i = 8'hA5;
        bc = 0;
        while (busy_o && bc < 100) begin
            bc++;
            tick();
        end
        wr_en_i = 1'b0;
        check("t5_busy_cnt", bc, 4);
        read_all(cells);
        check("t5_run_write_ignored", cells, 64'h1F);
        write_block(3'd1, 8'hA5);
        rd_addr_i = 3'd1;
        tick();
        check("t5_rd_a5", rd_data_o, 8'hA5);
        rd_addr_i = 3'd7;
        tick();
        check("t5_rd_last", rd_data_o, 8'h00);
        gen_count_i = 16'd1;
        start_i = 1'b1; wr_en_i = 1'b1; wr_addr_i = 3'd2; wr_data_i = 8'h3C;
        tick();
        start_i = 1'b0; wr_en_i = 1'b0;
        check("t5_start_ignored", busy_o, 0);
        read_all(cells);
        check("t5_collide_write", cells, 64'h3C_A5_1F);

        // 6: reset mid-run
        do_reset();
        cfg_rule_i = 8'd110; cfg_wrap_i = 1'b1; gen_count_i = 16'd5;
        start_i = 1'b1;
        tick();
        start_i = 1'b0;
        tick(); tick();
        reset = 1'b1;
        tick();
        check("t6_busy", busy_o, 0);
        check("t6_gen", gen_o, 0);
        check("t6_done", done_o, 0);
        reset = 1'b0;
        tick();
        check("t6_no_done", done_o, 0);
        read_all(cells);
        check("t6_cells", cells, 64'h1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
